// File: rtl/mem_read_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_read_arbiter_if
//
// Purpose: bundles every handshake/bus signal around the read arbiter:
//   - two requester read-address channels (index 0 = I-cache, 1 = D-cache)
//   - two requester read-data channels sharing one data bus
//   - the single memory-side read-address and read-data channels
//
// Signals:
//   m_arvalid[1:0], m_araddr[p], m_arlen[p], m_arid[p]  requester -> arbiter
//   m_arready[1:0]                                      arbiter   -> requester
//   m_rvalid[1:0], m_rdata                              arbiter   -> requester
//   m_rready[1:0]                                       requester -> arbiter
//   mem_arvalid, mem_araddr, mem_arlen, mem_arid        arbiter   -> memory
//   mem_arready                                         memory    -> arbiter
//   mem_rvalid, mem_rdata                               memory    -> arbiter
//   mem_rready                                          arbiter   -> memory
//
// Modports:
//   master : the arbiter's view (drives grants, memory requests, returned data)
//   slave  : the surrounding system's view (requesters plus memory model)
// ---------------------------------------------------------------------------
interface mem_read_arbiter_if #(
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 5
);
  // Requester read-address channels
  logic [1:0]                 m_arvalid;
  logic [1:0]                 m_arready;
  logic [1:0][ADDR_WIDTH-1:0] m_araddr;
  logic [1:0][LEN_WIDTH-1:0]  m_arlen;
  logic [1:0][3:0]            m_arid;

  // Requester read-data channels (shared data bus)
  logic [1:0]                 m_rvalid;
  logic [1:0]                 m_rready;
  logic [DATA_WIDTH-1:0]      m_rdata;

  // Memory read-address channel
  logic                       mem_arvalid;
  logic                       mem_arready;
  logic [ADDR_WIDTH-1:0]      mem_araddr;
  logic [LEN_WIDTH-1:0]       mem_arlen;
  logic [3:0]                 mem_arid;

  // Memory read-data channel
  logic                       mem_rvalid;
  logic                       mem_rready;
  logic [DATA_WIDTH-1:0]      mem_rdata;

  modport master (
    input  m_arvalid, m_araddr, m_arlen, m_arid, m_rready,
    input  mem_arready, mem_rvalid, mem_rdata,
    output m_arready, m_rvalid, m_rdata,
    output mem_arvalid, mem_araddr, mem_arlen, mem_arid, mem_rready
  );

  modport slave (
    output m_arvalid, m_araddr, m_arlen, m_arid, m_rready,
    output mem_arready, mem_rvalid, mem_rdata,
    input  m_arready, m_rvalid, m_rdata,
    input  mem_arvalid, mem_araddr, mem_arlen, mem_arid, mem_rready
  );
endinterface : mem_read_arbiter_if

// File: rtl/mem_read_arbiter.sv
// ---------------------------------------------------------------------------
// mem_read_arbiter
//
// Purpose: shares one memory read port between the I-cache (port 0) and the
// D-cache (port 1). One burst is outstanding at a time: IDLE picks a winner
// and latches its request, ADDR presents it to memory, DATA routes the
// returning beats to the winner until the last beat, then back to IDLE.
// While IDLE the memory read-data channel is held ready so stray beats (for
// example from a burst abandoned by reset) are drained and discarded.
//
// Ports:
//   clk   : clock
//   rst   : asynchronous, active-high reset
//   bus   : mem_read_arbiter_if.master (requester and memory channels)
//   busy  : 1 whenever a burst is in progress (state != IDLE)
//   grant : index of the requester owning the current/last burst
//
// Configuration:
//   MEM_ARB_ROUND_ROBIN_EN  defined   -> simultaneous requests alternate,
//                                        favouring the port not served by the
//                                        last completed burst
//                           undefined -> fixed priority, port 1 wins
// ---------------------------------------------------------------------------
module mem_read_arbiter #(
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 5
) (
  input  logic                clk,
  input  logic                rst,
  mem_read_arbiter_if.master  bus,
  output logic                busy,
  output logic                grant
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic                   grant_q, grant_d;
  logic [ADDR_WIDTH-1:0]  addr_q,  addr_d;
  logic [LEN_WIDTH-1:0]   len_q,   len_d;
  logic [3:0]             id_q,    id_d;
  logic [LEN_WIDTH-1:0]   beat_q,  beat_d;

  logic                   winner;
  logic [LEN_WIDTH-1:0]   last_beat;
  logic                   beat_fire;
  logic                   last_fire;

  // A latched length of 0 is a single-beat burst, so its last beat index is 0
  // just like a length of 1.
  assign last_beat = (len_q == '0) ? '0 : len_q - LEN_WIDTH'(1);
  assign beat_fire = (state_q == DATA) && bus.mem_rvalid && bus.m_rready[grant_q];
  assign last_fire = beat_fire && (beat_q == last_beat);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // rr_q holds the port favoured on the next simultaneous request; it moves
  // only when a burst completes, never at grant time.
  logic rr_q, rr_d;

  always_comb begin
    rr_d = rr_q;
    if (last_fire) rr_d = ~grant_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_q <= 1'b0;
    else     rr_q <= rr_d;
  end

  always_comb begin
    if (&bus.m_arvalid) winner = rr_q;
    else                winner = bus.m_arvalid[1];
  end
`else
  // Fixed priority: the D-cache wins any tie; a lone request always wins.
  assign winner = bus.m_arvalid[1];
`endif

  always_comb begin
    // NOTE: every signal written here is given a default first, so no branch
    // can leave a value unassigned and infer a latch.
    state_d = state_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    len_d   = len_q;
    id_d    = id_q;
    beat_d  = beat_q;

    bus.m_arready   = 2'b00;
    bus.m_rvalid    = 2'b00;
    bus.m_rdata     = bus.mem_rdata;
    bus.mem_arvalid = 1'b0;
    bus.mem_araddr  = addr_q;
    bus.mem_arlen   = len_q;
    bus.mem_arid    = id_q;
    bus.mem_rready  = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (|bus.m_arvalid) begin
          grant_d = winner;
          addr_d  = bus.m_araddr[winner];
          len_d   = bus.m_arlen[winner];
          id_d    = bus.m_arid[winner];
          state_d = ADDR;
        end
      end

      ADDR: begin
        // The request is already latched, so m_arvalid is not consulted here.
        bus.mem_arvalid        = 1'b1;
        bus.m_arready[grant_q] = bus.mem_arready;
        if (bus.mem_arready) begin
          beat_d  = '0;
          state_d = DATA;
        end
      end

      DATA: begin
        bus.m_rvalid[grant_q] = bus.mem_rvalid;
        bus.mem_rready        = bus.m_rready[grant_q];
        if (beat_fire) begin
          beat_d = beat_q + LEN_WIDTH'(1);
          if (last_fire) state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its _d value from before the edge, independent of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      id_q    <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      id_q    <= id_d;
      beat_q  <= beat_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign grant = grant_q;

endmodule : mem_read_arbiter

// File: tb/tb_mem_read_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_read_arbiter
//
// Directed bench for mem_read_arbiter. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge. A transaction-level
// model (owner, phase, beats remaining, tie-break preference) predicts every
// output each cycle; literal expectations pin addresses, beat data and grant
// order for the individual scenarios.
// ---------------------------------------------------------------------------
module tb_mem_read_arbiter;

  localparam int AW = 26;
  localparam int DW = 32;
  localparam int LW = 5;

  logic clk;
  logic rst;
  logic busy;
  logic grant;

  mem_read_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  mem_read_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .busy  (busy),
    .grant (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory responder state (driven from tick) -------------
  logic [DW-1:0] mq[$];          // beats still to be returned by memory
  logic [DW-1:0] data_base = 32'hA0;
  logic          rv_en     = 1'b1;
  logic          ar_rdy_en = 1'b1;

  // ---------------- values captured on the falling edge -------------------
  logic          r_hs_s    = 1'b0;
  logic          ar_hs_s   = 1'b0;
  logic [LW-1:0] ar_len_s  = '0;
  logic [1:0]    ar_drop_s = 2'b00;
  logic [DW-1:0] got0[$];
  logic [DW-1:0] got1[$];
  int            gq[$];          // DUT grant at each address handshake

  // ---------------- transaction-level model -------------------------------
  bit            md_busy;
  bit            md_data;        // 0: address phase, 1: data phase
  int            md_grant;
  int            md_left;        // beats still owed to the owner
  logic [AW-1:0] md_addr;
  logic [LW-1:0] md_len;
  logic [3:0]    md_id;
  int            md_pref;        // port preferred on a tie (round-robin build)

  always @(negedge clk) begin : compare
    logic [1:0] e_arready, e_rvalid;
    logic       e_arvalid, e_rready;
    int         pick;

    if (rst) begin
      md_busy = 0; md_data = 0; md_grant = 0; md_left = 0;
      md_addr = '0; md_len = '0; md_id = '0; md_pref = 0;
    end

    e_arvalid = md_busy && !md_data;
    e_arready = (e_arvalid && bus.mem_arready) ? (2'b01 << md_grant) : 2'b00;
    e_rvalid  = (md_busy && md_data && bus.mem_rvalid) ? (2'b01 << md_grant) : 2'b00;
    e_rready  = (md_busy && md_data) ? bus.m_rready[md_grant] : 1'b1;

    check("busy", busy, md_busy);
    check("grant", grant, md_grant[0]);
    check("mem_arvalid", bus.mem_arvalid, e_arvalid);
    check("m_arready", bus.m_arready, e_arready);
    check("m_rvalid", bus.m_rvalid, e_rvalid);
    check("mem_rready", bus.mem_rready, e_rready);
    if (e_arvalid) begin
      check("mem_araddr", bus.mem_araddr, md_addr);
      check("mem_arlen", bus.mem_arlen, md_len);
      check("mem_arid", bus.mem_arid, md_id);
    end
    if (e_rvalid != 2'b00) check("m_rdata", bus.m_rdata, bus.mem_rdata);

    // Logs and responder flags for the driver.
    r_hs_s    = bus.mem_rvalid && bus.mem_rready;
    ar_hs_s   = bus.mem_arvalid && bus.mem_arready;
    ar_len_s  = bus.mem_arlen;
    ar_drop_s = bus.m_arvalid & bus.m_arready;
    if (ar_hs_s) gq.push_back(int'(grant));
    if (bus.m_rvalid[0] && bus.m_rready[0]) got0.push_back(bus.m_rdata);
    if (bus.m_rvalid[1] && bus.m_rready[1]) got1.push_back(bus.m_rdata);

    // Advance the model to what the next rising edge produces.
    if (!rst) begin
      if (!md_busy) begin
        if (bus.m_arvalid != 2'b00) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
          pick = (bus.m_arvalid == 2'b11) ? md_pref : (bus.m_arvalid[1] ? 1 : 0);
`else
          pick = bus.m_arvalid[1] ? 1 : 0;
`endif
          md_busy  = 1; md_data = 0; md_grant = pick;
          md_addr  = bus.m_araddr[pick];
          md_len   = bus.m_arlen[pick];
          md_id    = bus.m_arid[pick];
          md_left  = (md_len == 0) ? 1 : int'(md_len);
        end
      end else if (!md_data) begin
        if (bus.mem_arready) md_data = 1;
      end else if (bus.mem_rvalid && bus.m_rready[md_grant]) begin
        md_left--;
        if (md_left == 0) begin
          md_busy = 0;
          md_pref = 1 - md_grant;
        end
      end
    end
  end

  // ---------------- driver helpers ----------------------------------------
  task automatic tick();
    int n;
    @(posedge clk);
    #1;
    if (r_hs_s && mq.size() > 0) void'(mq.pop_front());
    if (ar_hs_s) begin
      n = (ar_len_s == 0) ? 1 : int'(ar_len_s);
      for (int i = 0; i < n; i++) mq.push_back(data_base + DW'(i));
      bus.m_arvalid = bus.m_arvalid & ~ar_drop_s;
    end
    bus.mem_rvalid  = rv_en && (mq.size() > 0);
    bus.mem_rdata   = (mq.size() > 0) ? mq[0] : '0;
    bus.mem_arready = ar_rdy_en;
  endtask

  task automatic issue(input int p, input logic [AW-1:0] a, input logic [LW-1:0] l,
                       input logic [3:0] id);
    bus.m_arvalid[p] = 1'b1;
    bus.m_araddr[p]  = a;
    bus.m_arlen[p]   = l;
    bus.m_arid[p]    = id;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    do begin
      tick();
      k++;
    end while ((busy || mq.size() > 0 || bus.m_arvalid != 2'b00) && k < 300);
    if (k >= 300) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic wait_not_busy(input string name);
    int k = 0;
    while (busy && k < 300) begin
      tick();
      k++;
    end
    if (k >= 300) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic wait_beats(input int p, input int n, input string name);
    int k = 0;
    while (((p == 0) ? got0.size() : got1.size()) < n && k < 300) begin
      tick();
      k++;
    end
    if (k >= 300) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic wait_grants(input int n, input string name);
    int k = 0;
    while (gq.size() < n && k < 300) begin
      tick();
      k++;
    end
    if (k >= 300) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic clear_logs();
    got0.delete();
    got1.delete();
    gq.delete();
  endtask

  // ---------------- directed scenarios -------------------------------------
  int exp_a[2];
  int exp_b[4];

  initial begin
    rst             = 1'b1;
    bus.m_arvalid   = 2'b00;
    bus.m_araddr    = '0;
    bus.m_arlen     = '0;
    bus.m_arid      = '0;
    bus.m_rready    = 2'b11;
    bus.mem_arready = 1'b1;
    bus.mem_rvalid  = 1'b0;
    bus.mem_rdata   = '0;

    // Reset state
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_grant", grant, 0);
    check("rst_mem_rready", bus.mem_rready, 1);
    check("rst_mem_arvalid", bus.mem_arvalid, 0);
    rst = 1'b0;
    tick();

    // Single 4-beat burst from port 0
    clear_logs();
    data_base = 32'hA0;
    issue(0, 26'h100, 5'd4, 4'h3);
    #1 check("s1_arvalid_c0", bus.mem_arvalid, 0);
    tick();
    check("s1_arvalid_c1", bus.mem_arvalid, 1);
    check("s1_araddr", bus.mem_araddr, 26'h100);
    check("s1_arlen", bus.mem_arlen, 4);
    wait_idle("s1");
    check("s1_n0", got0.size(), 4);
    check("s1_n1", got1.size(), 0);
    for (int i = 0; i < 4 && i < got0.size(); i++)
      check($sformatf("s1_beat%0d", i), got0[i], 32'hA0 + i);
    check("s1_busy_end", busy, 0);

    // arlen = 0 is one beat, on port 1
    clear_logs();
    data_base = 32'h50;
    issue(1, 26'h200, 5'd0, 4'h5);
    wait_idle("s2");
    check("s2_n1", got1.size(), 1);
    if (got1.size() > 0) check("s2_beat", got1[0], 32'h50);

    // Simultaneous requests, each held until accepted
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_a = '{0, 1};
    exp_b = '{0, 1, 0, 1};
`else
    exp_a = '{1, 0};
    exp_b = '{1, 1, 1, 0};
`endif
    clear_logs();
    data_base = 32'h10;
    issue(0, 26'h300, 5'd2, 4'h1);
    issue(1, 26'h400, 5'd3, 4'h2);
    wait_idle("s3");
    check("s3_ngrants", gq.size(), 2);
    for (int i = 0; i < 2 && i < gq.size(); i++)
      check($sformatf("s3_grant%0d", i), gq[i], exp_a[i]);

    // Three back-to-back double requests
    clear_logs();
    data_base = 32'h20;
    for (int r = 0; r < 3; r++) begin
      issue(0, 26'h500, 5'd2, 4'h6);
      issue(1, 26'h600, 5'd2, 4'h7);
      wait_grants(r + 1, "s4_grant");
      wait_not_busy("s4_done");
    end
    wait_idle("s4");
    check("s4_ngrants", gq.size(), 4);
    for (int i = 0; i < 4 && i < gq.size(); i++)
      check($sformatf("s4_grant%0d", i), gq[i], exp_b[i]);

    // Requester stalls for 3 cycles mid-burst
    clear_logs();
    data_base = 32'hC0;
    issue(0, 26'h700, 5'd4, 4'h8);
    wait_beats(0, 2, "s5_pre");
    bus.m_rready[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("s5_rready%0d", i), bus.mem_rready, 0);
      check($sformatf("s5_hold%0d", i), got0.size(), 2);
    end
    bus.m_rready[0] = 1'b1;
    wait_idle("s5");
    check("s5_n0", got0.size(), 4);
    for (int i = 0; i < 4 && i < got0.size(); i++)
      check($sformatf("s5_beat%0d", i), got0[i], 32'hC0 + i);

    // Reset after beat 2 of 4; leftover beats must be swallowed
    clear_logs();
    data_base = 32'hE0;
    issue(1, 26'h800, 5'd4, 4'h9);
    wait_beats(1, 2, "s6_pre");
    rst = 1'b1;
    #1;
    check("s6_busy", busy, 0);
    check("s6_rvalid", bus.m_rvalid, 0);
    check("s6_rready", bus.mem_rready, 1);
    tick();
    rst = 1'b0;
    wait_idle("s6_drain");
    check("s6_n1", got1.size(), 2);
    check("s6_n0", got0.size(), 0);
    data_base = 32'h30;
    issue(0, 26'h900, 5'd2, 4'hA);
    wait_idle("s6_next");
    check("s6_next_n0", got0.size(), 2);
    if (got0.size() == 2) begin
      check("s6_next_b0", got0[0], 32'h30);
      check("s6_next_b1", got0[1], 32'h31);
    end

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_mem_read_arbiter

// File: doc/mem_read_arbiter.md
MEM_READ_ARBITER -- requirements
Module: mem_read_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 26, the byte-address width of read requests.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, the read-data beat width.
REQ-003 The block SHALL have parameter LEN_WIDTH, default 5, the burst-length field width, counted in beats.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-005 The block SHALL have port rst, input, 1 bit: the reset, asynchronous and active-high.
REQ-006 The block SHALL have ports m_arvalid, input [1:0]; m_arready, output [1:0]; m_araddr, input ADDR_WIDTH per port; m_arlen, input LEN_WIDTH per port; m_arid, input 4 bits per port. These carry the per-requester read-address channel: port 0 is the I-cache, port 1 is the D-cache.
REQ-007 The block SHALL have ports m_rvalid, output [1:0]; m_rready, input [1:0]; m_rdata, output DATA_WIDTH, shared by both requesters. These carry the per-requester read-data channel.
REQ-008 The block SHALL have ports mem_arvalid, output 1; mem_arready, input 1; mem_araddr, output ADDR_WIDTH; mem_arlen, output LEN_WIDTH; mem_arid, output 4. These form the memory-side read-address channel.
REQ-009 The block SHALL have ports mem_rvalid, input 1; mem_rready, output 1; mem_rdata, input DATA_WIDTH. These form the memory-side read-data channel.
REQ-010 The block SHALL have ports busy, output 1, and grant, output 1 (the index of the owning requester).

Function
REQ-011 The block SHALL implement the states IDLE, ADDR and DATA, with only one burst outstanding at any time.
REQ-012 In IDLE, if any m_arvalid is high, the block SHALL select a winner, latch its araddr/arlen/arid and its index into grant, and move to ADDR on the next edge.
REQ-013 In IDLE, m_arready SHALL be 0 and mem_arvalid SHALL be 0.
REQ-014 In ADDR, mem_arvalid SHALL be 1 and driven with the latched fields; m_arready[grant] SHALL equal mem_arready, and the other m_arready bit SHALL be 0.
REQ-015 In ADDR, when mem_arready is high the block SHALL clear the beat counter and move to DATA.
REQ-016 In DATA, m_rvalid[grant] SHALL equal mem_rvalid, the other m_rvalid bit SHALL be 0, m_rdata SHALL equal mem_rdata, and mem_rready SHALL equal m_rready[grant].
REQ-017 Each beat where mem_rvalid and mem_rready are both high SHALL increment the beat counter; the beat with counter equal to len-1 SHALL return the block to IDLE.
REQ-018 A latched arlen of 0 SHALL be treated as a 1-beat burst.
REQ-019 The beat counter SHALL be LEN_WIDTH bits wide and SHALL support a maximum length of 2^LEN_WIDTH-1 beats.
REQ-020 The earliest mem_arvalid SHALL occur one cycle after m_arvalid rises in IDLE.
REQ-021 After the last beat the block SHALL spend one IDLE cycle before the next grant.
REQ-022 In IDLE, mem_rready SHALL be 1 so that stray beats are discarded, and m_rvalid SHALL be 0.
REQ-023 busy SHALL be 1 whenever the state is not IDLE.
REQ-024 The grant register SHALL hold its value in IDLE.
REQ-025 m_arvalid deasserting during ADDR SHALL be ignored, because the request is already latched.

Reset
REQ-026 When rst is asserted, the state SHALL become IDLE, grant SHALL be 0, the beat counter SHALL be 0, the latched request fields SHALL be 0 and the round-robin pointer SHALL favour port 0, all asynchronously.
REQ-027 Under reset, the outputs SHALL be m_arready=0, m_rvalid=0, mem_arvalid=0, mem_rready=1, busy=0.
REQ-028 A reset in the middle of a burst SHALL abandon that burst, and any later memory beats from it SHALL be discarded per REQ-022.

Configuration
REQ-029 With macro MEM_ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL be granted to the port not served by the last completed burst, and the pointer SHALL update when that burst's last beat completes.
REQ-030 Without MEM_ARB_ROUND_ROBIN_EN, simultaneous requests SHALL use fixed priority with port 1 (D-cache) winning.
REQ-031 A lone request SHALL be granted regardless of whether MEM_ARB_ROUND_ROBIN_EN is defined.

Verification
REQ-032 Port 0 requests addr 0x100, len 4, with mem_arready high: at cycle 1 mem_araddr=0x100 and mem_arlen=4; 4 beats 0xA0..0xA3 appear only on m_rvalid[0]; busy falls after beat 4.
REQ-033 Both ports request in the same cycle without the macro: port 1 is granted first; port 0 is granted on the first IDLE grant after port 1's last beat.
REQ-034 With the macro, three back-to-back double requests give the grant sequence 0,1,0.
REQ-035 m_rready[grant] is held low for 3 cycles mid-burst: mem_rready stays low, the counter holds, and all 4 beats are delivered in order.
REQ-036 rst is asserted after beat 2 of 4: the block is IDLE immediately, the remaining 2 beats are consumed with m_rvalid=0, and the next request is served normally.
REQ-037 A request with arlen=0 completes after exactly 1 beat.
